// File: rtl/rm_pkg.sv
// Shared types and helpers for the runtime-monitor violation logger.
//   rm_viol_rec_t         : one queued violation record {lane, rule, ts}
//   RM_LANE_W / RM_RULE_W : record field widths
//   rm_flat_to_lane_rule(): flat verdict index + timestamp -> record
package rm_pkg;

  localparam int unsigned RM_NUM_LANES = 2;
  localparam int unsigned RM_NUM_RULES = 10;
  localparam int unsigned RM_TS_W      = 32;

  localparam int unsigned RM_LANE_W = (RM_NUM_LANES > 1) ? $clog2(RM_NUM_LANES) : 1;
  localparam int unsigned RM_RULE_W = $clog2(RM_NUM_RULES);
  localparam int unsigned RM_FLAT_N = RM_NUM_LANES * RM_NUM_RULES;
  localparam int unsigned RM_FLAT_W = $clog2(RM_FLAT_N);

  typedef struct packed {
    logic [RM_LANE_W-1:0] lane;
    logic [RM_RULE_W-1:0] rule;
    logic [RM_TS_W-1:0]   ts;
  } rm_viol_rec_t;

  // Flat index f = lane * RM_NUM_RULES + rule.
  function automatic rm_viol_rec_t rm_flat_to_lane_rule(input logic [RM_FLAT_W-1:0] f,
                                                        input logic [RM_TS_W-1:0]   ts);
    rm_viol_rec_t rec;
    rec.lane = RM_LANE_W'(32'(f) / RM_NUM_RULES);
    rec.rule = RM_RULE_W'(32'(f) % RM_NUM_RULES);
    rec.ts   = ts;
    return rec;
  endfunction

endpackage

// File: rtl/rm_event_fifo.sv
// Show-ahead FIFO for event records.
//   clk_i/reset_i : clock, synchronous active-high reset
//   flush_i       : empty the FIFO; no push or pop takes effect that cycle
//   push_i/data_i : write request (dropped when full unless popping the same cycle)
//   pop_i         : consume the head (ignored when empty)
//   data_o        : head entry, zero while empty; valid_o = not empty
//   count_o/full_o/empty_o : occupancy
module rm_event_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic            push_en, pop_en;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign valid_o = ~empty_o;

  assign pop_en  = pop_i & ~empty_o & ~flush_i;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign push_en = push_i & (~full_o | pop_en) & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) wr_q <= wr_q + 1'b1;
      if (pop_en)  rd_q <= rd_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_q] <= data_i;
  end

  always_comb begin
    data_o = T'('0);
    if (!empty_o) data_o = mem_q[rd_q];
  end

endmodule

// File: rtl/rm_violation_logger.sv
// Violation logger behind the runtime-monitor lanes.
// Detects 0->1 edges on lane verdicts, holds them as pending bits, grants the lowest flat
// index into a timestamped record FIFO one per cycle, and counts edges lost on bits
// that were already pending.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   enable_i              : capture new violations
//   clear_i               : flush FIFO, pending bits and overflow count
//   monitor_i             : lane verdict levels, 1 = violated
//   rec_valid_o/rec_ready_i : record handshake; rec_lane_o/rec_rule_o/rec_ts_o = head
//   irq_o                 : registered FIFO-non-empty
//   pending_o             : violations seen but not yet queued, flat order
//   overflow_o            : saturating lost-event count
// Record field widths come from rm_pkg; keep NUM_LANES/NUM_RULES/TS_WIDTH consistent with it.
module rm_violation_logger
  import rm_pkg::*;
#(
  parameter int unsigned NUM_LANES  = RM_NUM_LANES,
  parameter int unsigned NUM_RULES  = RM_NUM_RULES,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_WIDTH   = RM_TS_W
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 enable_i,
  input  logic                                 clear_i,
  input  logic [NUM_LANES-1:0][NUM_RULES-1:0]  monitor_i,
  output logic                                 rec_valid_o,
  input  logic                                 rec_ready_i,
  output logic [RM_LANE_W-1:0]                 rec_lane_o,
  output logic [RM_RULE_W-1:0]                 rec_rule_o,
  output logic [TS_WIDTH-1:0]                  rec_ts_o,
  output logic                                 irq_o,
  output logic [NUM_LANES*NUM_RULES-1:0]       pending_o,
  output logic [15:0]                          overflow_o
);

  localparam int unsigned FlatN = NUM_LANES * NUM_RULES;
  localparam int unsigned LostW = $clog2(FlatN + 1);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  logic [FlatN-1:0]     mon_flat, prev_q, pending_q, pending_d;
  logic [FlatN-1:0]     new_edge, lowest, grant, lost;
  logic [RM_FLAT_W-1:0] grant_idx;
  logic                 any_pending, push_ok, push_en, pop_en;
  logic [LostW-1:0]     lost_cnt;
  logic [16:0]          ovf_sum;
  logic [15:0]          overflow_q, overflow_d;
  logic [TS_WIDTH-1:0]  ts_q;
  logic                 irq_q;
  logic                 fifo_full, fifo_empty;
  logic [CntW-1:0]      fifo_cnt;
  rm_viol_rec_t         push_rec, head_rec;

  // Packed [lane][rule] flattens to bit lane*NUM_RULES + rule.
  assign mon_flat = monitor_i;
  assign new_edge = mon_flat & ~prev_q & {FlatN{enable_i}};

  // Isolate the lowest pending bit; the loop only encodes its index.
  assign lowest      = pending_q & (~pending_q + 1'b1);
  assign any_pending = |pending_q;

  always_comb begin
    grant_idx = '0;
    for (int i = int'(FlatN) - 1; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = RM_FLAT_W'(i);
    end
  end

  assign push_ok = ~fifo_full | (rec_valid_o & rec_ready_i);
  assign push_en = any_pending & push_ok & ~clear_i;
  assign pop_en  = rec_valid_o & rec_ready_i & ~clear_i;
  assign grant   = push_en ? lowest : '0;
  assign lost    = new_edge & pending_q & ~grant;

  assign push_rec = rm_flat_to_lane_rule(grant_idx, RM_TS_W'(ts_q));

  always_comb begin
    lost_cnt = '0;
    for (int i = 0; i < int'(FlatN); i++) begin
      lost_cnt = lost_cnt + LostW'(lost[i]);
    end
  end

  always_comb begin
    ovf_sum    = {1'b0, overflow_q} + 17'(lost_cnt);
    overflow_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    // A fresh edge on the granted bit keeps it pending for a later record.
    pending_d  = (pending_q & ~grant) | new_edge;
    if (clear_i) begin
      overflow_d = '0;
      pending_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      ts_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      // prev tracks the verdicts even when disabled or clearing, so held levels never re-fire.
      prev_q     <= mon_flat;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      ts_q       <= ts_q + 1'b1;
      irq_q      <= (fifo_cnt != '0);
    end
  end

  rm_event_fifo #(
    .T     (rm_viol_rec_t),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (clear_i),
    .push_i  (push_en),
    .data_i  (push_rec),
    .pop_i   (pop_en),
    .data_o  (head_rec),
    .valid_o (rec_valid_o),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_lane_o = fifo_empty ? '0 : head_rec.lane;
  assign rec_rule_o = head_rec.rule;
  assign rec_ts_o   = TS_WIDTH'(head_rec.ts);
  assign irq_o      = irq_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule
